mem_port_arbiter: RTL and testbench

Shares the single unified memory port of the multicycle RV32I core between the instruction-fetch path and the load/store path. It queues one request per port, grants by fixed priority and drives the memory handshake with wait-state and timeout handling. It also performs RV32I byte/halfword store lane steering and load extraction with sign or zero extension. It sits between the decode/control FSM and the external memory, and replaces direct IorD muxing of the address.

---
 rtl/mem_port_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store: data wins, 2 cycles + wait states per access, illegal requests answer in 1.
// Each port holds one pending request; further pulses on a busy port are dropped, and a stalled mem_req is cut off after TIMEOUT cycles.
module mem_port_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    function automatic logic data_legal(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic size_ok;
        case (f3[1:0])
            2'b00:   size_ok = 1'b1;
            2'b01:   size_ok = ~a[0];
            2'b10:   size_ok = (a == 2'b00);
            default: size_ok = 1'b0;
        endcase
        data_legal = size_ok && (we ? !f3[2] : !(f3[2] && f3[1]));
    endfunction

    function automatic logic [3:0] store_strb(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'b00:   store_strb = 4'b0001 << a;
            2'b01:   store_strb = a[1] ? 4'b1100 : 4'b0011;
            default: store_strb = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] w);
        case (sz)
            2'b00:   store_data = {4{w[7:0]}};
            2'b01:   store_data = {2{w[15:0]}};
            default: store_data = w;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
        logic [31:0] sh;
        sh = w >> {a, 3'b000};
        case (f3)
            3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
            3'b001:  load_ext = {{16{sh[15]}}, sh[15:0]};
            3'b100:  load_ext = {24'h0, sh[7:0]};
            3'b101:  load_ext = {16'h0, sh[15:0]};
            default: load_ext = w;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic        owner_q, owner_d;      // 1 = data port owns the current access
    logic [31:0] cnt_q, cnt_d;
    logic        if_pend_q, if_pend_d;
    logic [31:0] if_addr_q, if_addr_d;
    logic        d_pend_q, d_pend_d, d_we_q, d_we_d;
    logic [2:0]  d_funct3_q, d_funct3_d;
    logic [31:0] d_addr_q, d_addr_d, d_wdata_q, d_wdata_d;
    logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic        if_valid_q, if_valid_d, if_err_q, if_err_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        d_valid_q, d_valid_d, d_err_q, d_err_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic        if_clr, d_clr, d_we_e;
    logic [31:0] if_addr_e, d_addr_e, d_wdata_e;
    logic [2:0]  d_f3_e;

    always_comb begin
        state_d = state_q;  owner_d = owner_q;  cnt_d = cnt_q;
        if_pend_d = if_pend_q;  if_addr_d = if_addr_q;
        d_pend_d = d_pend_q;  d_we_d = d_we_q;  d_funct3_d = d_funct3_q;
        d_addr_d = d_addr_q;  d_wdata_d = d_wdata_q;
        mem_req_d = mem_req_q;  mem_we_d = mem_we_q;  mem_addr_d = mem_addr_q;
        mem_wdata_d = mem_wdata_q;  mem_wstrb_d = mem_wstrb_q;
        if_valid_d = 1'b0;  if_err_d = if_err_q;  if_rdata_d = if_rdata_q;
        d_valid_d = 1'b0;  d_err_d = d_err_q;  d_rdata_d = d_rdata_q;

        // A request arriving now is visible to the IDLE grant before it lands in the latches.
        if_addr_e = if_pend_q ? if_addr_q : if_addr;
        d_we_e    = d_pend_q ? d_we_q : d_we;
        d_f3_e    = d_pend_q ? d_funct3_q : d_funct3;
        d_addr_e  = d_pend_q ? d_addr_q : d_addr;
        d_wdata_e = d_pend_q ? d_wdata_q : d_wdata;

        if_clr = (state_q == RESP) && !owner_q;
        d_clr  = (state_q == RESP) && owner_q;
        if (if_clr) if_pend_d = 1'b0;
        if (d_clr)  d_pend_d  = 1'b0;
        if (if_req && (!if_pend_q || if_clr)) begin
            if_pend_d = 1'b1;
            if_addr_d = if_addr;
        end
        if (d_req && (!d_pend_q || d_clr)) begin
            d_pend_d = 1'b1;  d_we_d = d_we;  d_funct3_d = d_funct3;
            d_addr_d = d_addr;  d_wdata_d = d_wdata;
        end

        case (state_q)
            IDLE: begin
                if (d_pend_q || d_req) begin
                    owner_d = 1'b1;
                    if (data_legal(d_we_e, d_f3_e, d_addr_e[1:0])) begin
                        state_d = ACCESS;  cnt_d = '0;  mem_req_d = 1'b1;  mem_we_d = d_we_e;
                        mem_addr_d  = {d_addr_e[31:2], 2'b00};
                        mem_wstrb_d = d_we_e ? store_strb(d_f3_e[1:0], d_addr_e[1:0]) : 4'b0000;
                        mem_wdata_d = d_we_e ? store_data(d_f3_e[1:0], d_wdata_e) : 32'h0;
                    end else begin
                        state_d = RESP;  d_valid_d = 1'b1;  d_err_d = 1'b1;  d_rdata_d = '0;
                    end
                end else if (if_pend_q || if_req) begin
                    owner_d = 1'b0;
                    if (if_addr_e[1:0] == 2'b00) begin
                        state_d = ACCESS;  cnt_d = '0;  mem_req_d = 1'b1;  mem_we_d = 1'b0;
                        mem_addr_d = {if_addr_e[31:2], 2'b00};
                        mem_wstrb_d = 4'b0000;  mem_wdata_d = 32'h0;
                    end else begin
                        state_d = RESP;  if_valid_d = 1'b1;  if_err_d = 1'b1;  if_rdata_d = '0;
                    end
                end
            end
            ACCESS: begin
                if (mem_ready || (TO_EN && cnt_q == TO_LAST)) begin
                    state_d = RESP;  mem_req_d = 1'b0;  mem_we_d = 1'b0;  mem_wstrb_d = 4'b0000;
                    if (owner_q) begin
                        d_valid_d = 1'b1;  d_err_d = !mem_ready;
                        d_rdata_d = (mem_ready && !d_we_q) ? load_ext(d_funct3_q, d_addr_q[1:0], mem_rdata) : 32'h0;
                    end else begin
                        if_valid_d = 1'b1;  if_err_d = !mem_ready;
                        if_rdata_d = mem_ready ? mem_rdata : 32'h0;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;  owner_q <= 1'b0;  cnt_q <= '0;
            if_pend_q <= 1'b0;  if_addr_q <= '0;
            d_pend_q <= 1'b0;  d_we_q <= 1'b0;  d_funct3_q <= '0;  d_addr_q <= '0;  d_wdata_q <= '0;
            mem_req_q <= 1'b0;  mem_we_q <= 1'b0;  mem_addr_q <= '0;  mem_wdata_q <= '0;  mem_wstrb_q <= '0;
            if_valid_q <= 1'b0;  if_err_q <= 1'b0;  if_rdata_q <= '0;
            d_valid_q <= 1'b0;  d_err_q <= 1'b0;  d_rdata_q <= '0;
        end else begin
            state_q <= state_d;  owner_q <= owner_d;  cnt_q <= cnt_d;
            if_pend_q <= if_pend_d;  if_addr_q <= if_addr_d;
            d_pend_q <= d_pend_d;  d_we_q <= d_we_d;  d_funct3_q <= d_funct3_d;
            d_addr_q <= d_addr_d;  d_wdata_q <= d_wdata_d;
            mem_req_q <= mem_req_d;  mem_we_q <= mem_we_d;  mem_addr_q <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;  mem_wstrb_q <= mem_wstrb_d;
            if_valid_q <= if_valid_d;  if_err_q <= if_err_d;  if_rdata_q <= if_rdata_d;
            d_valid_q <= d_valid_d;  d_err_q <= d_err_d;  d_rdata_q <= d_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign if_valid  = if_valid_q;
    assign if_err    = if_err_q;
    assign if_rdata  = if_rdata_q;
    assign d_valid   = d_valid_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state_q != IDLE) || if_pend_q || d_pend_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed timing scenarios plus random traffic against a byte-level memory model.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1, if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [2:0]  d_funct3 = '0;
    logic        if_valid, if_err, d_valid, d_err, mem_req, mem_we, mem_ready, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int checks = 0, errors = 0;

    // Memory responder: fixed or address-derived wait states, forced or array-backed read data.
    int          ws_force = 0;
    int          age = 0;
    logic        rd_force_en = 1'b1, mem_init = 1'b0;
    logic [31:0] rd_force = '0;
    logic [31:0] mem_img [256];
    logic [1:0]  addr_ws;
    assign addr_ws   = (mem_addr[3:2] == 2'd3) ? 2'd0 : mem_addr[3:2];
    assign mem_ready = mem_req && ((ws_force >= 0) ? (age == ws_force) : (age == int'(addr_ws)));
    assign mem_rdata = rd_force_en ? rd_force : mem_img[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_req && !mem_ready) age <= age + 1;
        else age <= 0;
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem_img[i] <= (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
        end else if (mem_req && mem_ready && mem_we) begin
            for (int k = 0; k < 4; k++)
                if (mem_wstrb[k]) mem_img[mem_addr[9:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
        end
    end

    mem_port_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;  mem_init = 1'b1;
        repeat (3) step();
        reset = 1'b0;  mem_init = 1'b0;
        checks++;
        if ({mem_req, mem_we, mem_wstrb, if_valid, if_err, d_valid, d_err, busy} !== 11'h0) begin
            errors++;  $display("FAIL reset_ctrl: got %b required 0", {mem_req, mem_we, mem_wstrb, if_valid, if_err, d_valid, d_err, busy});
        end
        checks++;
        if ({mem_addr, mem_wdata} !== 64'h0) begin
            errors++;  $display("FAIL reset_mem_bus: got %h required 0", {mem_addr, mem_wdata});
        end
        checks++;
        if ({if_rdata, d_rdata} !== 64'h0) begin
            errors++;  $display("FAIL reset_rdata: got %h required 0", {if_rdata, d_rdata});
        end
    endtask

    task automatic test_fetch_zero_wait;
        ws_force = 0;  rd_force_en = 1'b1;  rd_force = 32'h015a04b3;
        if_req = 1'b1;  if_addr = 32'h100;
        step();
        if_req = 1'b0;  if_addr = 32'hdeadbeef;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || mem_wstrb !== 4'b0) begin
            errors++;  $display("FAIL fetch_c1: req=%b addr=%h we=%b strb=%b required 1 00000100 0 0000", mem_req, mem_addr, mem_we, mem_wstrb);
        end
        step();
        checks++;
        if (if_valid !== 1'b1 || if_rdata !== 32'h015a04b3 || if_err !== 1'b0) begin
            errors++;  $display("FAIL fetch_c2: valid=%b rdata=%h err=%b required 1 015a04b3 0", if_valid, if_rdata, if_err);
        end
        step();
        checks++;
        if (if_valid !== 1'b0 || if_rdata !== 32'h015a04b3) begin
            errors++;  $display("FAIL fetch_hold: valid=%b rdata=%h required 0 015a04b3", if_valid, if_rdata);
        end
    endtask

    task automatic test_simultaneous;
        int dv, fq, iv;
        logic first_seen;
        logic [31:0] first_addr, fq_addr, dval;
        dv = -1;  fq = -1;  iv = -1;  first_seen = 1'b0;  first_addr = '0;  fq_addr = '0;  dval = '0;
        ws_force = 2;  rd_force = 32'h12345678;
        if_req = 1'b1;  if_addr = 32'h104;
        d_req = 1'b1;  d_we = 1'b0;  d_funct3 = 3'b010;  d_addr = 32'h204;
        for (int c = 1; c <= 12; c++) begin
            step();
            if_req = 1'b0;  d_req = 1'b0;
            if (mem_req && !first_seen) begin first_seen = 1'b1; first_addr = mem_addr; end
            if (d_valid && dv < 0) begin dv = c; dval = d_rdata; end
            if (mem_req && dv >= 0 && fq < 0) begin fq = c; fq_addr = mem_addr; end
            if (if_valid && iv < 0) iv = c;
        end
        checks++;
        if (first_addr !== 32'h204) begin errors++; $display("FAIL sim_first_addr: got %h required 00000204", first_addr); end
        checks++;
        if (dv != 4 || dval !== 32'h12345678) begin errors++; $display("FAIL sim_d_valid: cycle %0d data %h required 4 12345678", dv, dval); end
        checks++;
        if (fq != 6 || fq_addr !== 32'h104) begin errors++; $display("FAIL sim_fetch_start: cycle %0d addr %h required 6 00000104", fq, fq_addr); end
        checks++;
        if (iv != 9) begin errors++; $display("FAIL sim_if_valid: cycle %0d required 9", iv); end
    endtask

    task automatic test_loads;
        logic [2:0]  f3s [5];
        logic [31:0] ads [5], exps [5];
        int n;
        f3s  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        ads  = '{32'h203, 32'h203, 32'h202, 32'h202, 32'h200};
        exps = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h80FF1234};
        ws_force = 0;  rd_force = 32'h80FF1234;
        for (int i = 0; i < 5; i++) begin
            d_req = 1'b1;  d_we = 1'b0;  d_funct3 = f3s[i];  d_addr = ads[i];
            step();
            d_req = 1'b0;
            n = 0;
            while (!d_valid && n < 6) begin step(); n++; end
            checks++;
            if (d_valid !== 1'b1 || n != 1 || d_rdata !== exps[i] || d_err !== 1'b0) begin
                errors++;
                $display("FAIL load_%0d: valid=%b lat=%0d rdata=%h err=%b required 1 1 %h 0", i, d_valid, n, d_rdata, d_err, exps[i]);
            end
            step();
        end
    endtask

    task automatic test_stores;
        logic [2:0]  f3s [4];
        logic [31:0] ads [4], wds [4], exps [4];
        logic [3:0]  strbs [4];
        f3s   = '{3'b001, 3'b000, 3'b010, 3'b001};
        ads   = '{32'h302, 32'h301, 32'h300, 32'h300};
        wds   = '{32'h0000ABCD, 32'h123456EF, 32'hCAFEF00D, 32'h00001234};
        exps  = '{32'hABCDABCD, 32'hEFEFEFEF, 32'hCAFEF00D, 32'h12341234};
        strbs = '{4'b1100, 4'b0010, 4'b1111, 4'b0011};
        ws_force = 0;
        for (int i = 0; i < 4; i++) begin
            d_req = 1'b1;  d_we = 1'b1;  d_funct3 = f3s[i];  d_addr = ads[i];  d_wdata = wds[i];
            step();
            d_req = 1'b0;
            checks++;
            if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h300 || mem_wstrb !== strbs[i] || mem_wdata !== exps[i]) begin
                errors++;
                $display("FAIL store_%0d: req/we=%b addr=%h strb=%b wdata=%h required 11 00000300 %b %h", i, {mem_req, mem_we}, mem_addr, mem_wstrb, mem_wdata, strbs[i], exps[i]);
            end
            step();
            checks++;
            if (d_valid !== 1'b1 || d_err !== 1'b0) begin
                errors++;  $display("FAIL store_resp_%0d: valid=%b err=%b required 1 0", i, d_valid, d_err);
            end
            step();
        end
    endtask

    task automatic test_illegal;
        logic        is_d [6], wes [6];
        logic [2:0]  f3s [6];
        logic [31:0] ads [6];
        logic        v, e;
        is_d = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        wes  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        f3s  = '{3'b010, 3'b000, 3'b011, 3'b100, 3'b001, 3'b001};
        ads  = '{32'h201, 32'h102, 32'h200, 32'h200, 32'h203, 32'h201};
        for (int i = 0; i < 6; i++) begin
            if (is_d[i]) begin d_req = 1'b1; d_we = wes[i]; d_funct3 = f3s[i]; d_addr = ads[i]; end
            else begin if_req = 1'b1; if_addr = ads[i]; end
            step();
            d_req = 1'b0;  if_req = 1'b0;
            v = is_d[i] ? d_valid : if_valid;
            e = is_d[i] ? d_err : if_err;
            checks++;
            if (mem_req !== 1'b0 || v !== 1'b1 || e !== 1'b1) begin
                errors++;  $display("FAIL illegal_%0d: mem_req=%b valid=%b err=%b required 0 1 1", i, mem_req, v, e);
            end
            step();
            checks++;
            if (mem_req !== 1'b0 || d_valid !== 1'b0 || if_valid !== 1'b0) begin
                errors++;  $display("FAIL illegal_after_%0d: mem_req=%b valid=%b%b required 0 00", i, mem_req, d_valid, if_valid);
            end
        end
    endtask

    task automatic test_timeout;
        ws_force = 0;  rd_force = 32'hA5A5A5A5;
        d_req = 1'b1;  d_we = 1'b0;  d_funct3 = 3'b010;  d_addr = 32'h200;
        step();  d_req = 1'b0;  step();
        checks++;
        if (d_valid !== 1'b1 || d_rdata !== 32'hA5A5A5A5) begin
            errors++;  $display("FAIL pre_timeout_load: valid=%b rdata=%h required 1 a5a5a5a5", d_valid, d_rdata);
        end
        step();
        ws_force = 1000;
        d_req = 1'b1;  d_addr = 32'h208;
        for (int c = 1; c <= 17; c++) begin
            step();
            d_req = 1'b0;
            checks++;
            if (mem_req !== (c <= 16) || d_valid !== (c == 17)) begin
                errors++;  $display("FAIL timeout_c%0d: mem_req=%b valid=%b required %b %b", c, mem_req, d_valid, c <= 16, c == 17);
            end
        end
        checks++;
        if (d_err !== 1'b1 || d_rdata !== 32'h0) begin
            errors++;  $display("FAIL timeout_resp: err=%b rdata=%h required 1 00000000", d_err, d_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid;
        logic seen;
        ws_force = 1000;
        d_req = 1'b1;  d_we = 1'b0;  d_funct3 = 3'b010;  d_addr = 32'h20C;
        if_req = 1'b1;  if_addr = 32'h110;
        for (int c = 1; c <= 5; c++) begin
            step();
            d_req = 1'b0;  if_req = 1'b0;
        end
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h20C) begin
            errors++;  $display("FAIL midreset_pre: mem_req=%b addr=%h required 1 0000020c", mem_req, mem_addr);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;  ws_force = 0;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            errors++;  $display("FAIL midreset_c6: mem_req=%b busy=%b required 0 0", mem_req, busy);
        end
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (mem_req || d_valid || if_valid || busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;  $display("FAIL midreset_dropped: activity seen=%b required 0", seen);
        end
    endtask

    // Reference model: memory as bytes, RV32I load/store rules applied directly.
    logic [7:0] ref_b [1024];

    function automatic logic ref_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic ok;
        ok = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (f3 == 3'd2 && a % 4 != 0) ok = 1'b0;
        if ((f3 == 3'd1 || f3 == 3'd5) && a % 2 != 0) ok = 1'b0;
        return ok;
    endfunction

    task automatic test_random;
        logic        if_out, d_out, if_eerr, d_eerr, d_chk, we;
        logic [31:0] if_exp, d_exp, a, v, wd;
        logic [2:0]  f3;
        int          if_age, d_age, nb;
        if_out = 1'b0;  d_out = 1'b0;  if_age = 0;  d_age = 0;
        if_eerr = 1'b0;  d_eerr = 1'b0;  d_chk = 1'b0;  if_exp = '0;  d_exp = '0;
        for (int i = 0; i < 256; i++)
            for (int k = 0; k < 4; k++) ref_b[4*i + k] = mem_img[i][8*k +: 8];
        rd_force_en = 1'b0;  ws_force = -1;
        for (int cyc = 0; cyc < 640; cyc++) begin
            if (if_valid) begin
                checks++;
                if (!if_out || if_err !== if_eerr || (!if_eerr && if_rdata !== if_exp)) begin
                    errors++;  $display("FAIL rnd_fetch cyc %0d: out=%b err=%b rdata=%h required 1 %b %h", cyc, if_out, if_err, if_rdata, if_eerr, if_exp);
                end
                if_out = 1'b0;
            end
            if (d_valid) begin
                checks++;
                if (!d_out || d_err !== d_eerr || (d_chk && d_rdata !== d_exp)) begin
                    errors++;  $display("FAIL rnd_data cyc %0d: out=%b err=%b rdata=%h required 1 %b %h", cyc, d_out, d_err, d_rdata, d_eerr, d_exp);
                end
                d_out = 1'b0;
            end
            if (if_out && ++if_age > 60) begin
                checks++;  errors++;  if_out = 1'b0;
                $display("FAIL rnd_fetch_wait: no if_valid within 60 cycles");
            end
            if (d_out && ++d_age > 60) begin
                checks++;  errors++;  d_out = 1'b0;
                $display("FAIL rnd_data_wait: no d_valid within 60 cycles");
            end
            if_req = 1'b0;  d_req = 1'b0;
            if (cyc < 600) begin
                if (!if_out && $urandom_range(0, 2) == 0) begin
                    a = 32'($urandom_range(0, 511));
                    if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                    if_req = 1'b1;  if_addr = a;  if_out = 1'b1;  if_age = 0;
                    if_eerr = (a % 4 != 0);
                    a = a & ~32'h3;
                    if_exp = {ref_b[a+3], ref_b[a+2], ref_b[a+1], ref_b[a]};
                end else if (if_out && $urandom_range(0, 7) == 0) begin
                    if_req = 1'b1;  if_addr = $urandom;
                end
                if (!d_out && $urandom_range(0, 1) == 0) begin
                    f3 = 3'($urandom_range(0, 7));  we = 1'($urandom_range(0, 1));
                    a = 32'($urandom_range(512, 1023));  wd = $urandom;
                    if ($urandom_range(0, 3) != 0) begin
                        if (f3 == 3'd2) a = a & ~32'h3;
                        else if (f3 == 3'd1 || f3 == 3'd5) a = a & ~32'h1;
                    end
                    d_req = 1'b1;  d_we = we;  d_funct3 = f3;  d_addr = a;  d_wdata = wd;
                    d_out = 1'b1;  d_age = 0;
                    d_eerr = !ref_legal(we, f3, a);
                    d_chk = !d_eerr && !we;
                    nb = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
                    if (!d_eerr && we) begin
                        for (int k = 0; k < nb; k++) ref_b[a + k] = wd[8*k +: 8];
                    end else if (d_chk) begin
                        v = '0;
                        for (int k = 0; k < nb; k++) v = v | (32'(ref_b[a + k]) << (8 * k));
                        if (f3 == 3'd0 && v[7])  v = v | 32'hFFFFFF00;
                        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
                        d_exp = v;
                    end
                end else if (d_out && $urandom_range(0, 7) == 0) begin
                    d_req = 1'b1;  d_we = 1'($urandom_range(0, 1));  d_funct3 = 3'($urandom_range(0, 7));
                    d_addr = $urandom;  d_wdata = $urandom;
                end
            end
            step();
        end
        checks++;
        if (if_out || d_out) begin
            errors++;  $display("FAIL rnd_drain: outstanding fetch=%b data=%b required 0 0", if_out, d_out);
        end
    endtask

    initial begin
        step();
        test_reset();
        test_fetch_zero_wait();
        test_simultaneous();
        test_loads();
        test_stores();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
